feature_vector_serializer: RTL and testbench

Drains a parallel feature vector, such as the 1280-entry `data_out` array produced by the final-layer batch norm, into a one-element-per-transfer stream with a valid/ready handshake. Downstream sequential consumers (classifier MAC, debug/readout port) can then apply backpressure. It sits directly after the final-layer normalisation stage. It accepts the same parallel-array + `valid_in` pulse interface that stage emits on its output side.

---
 rtl/feature_vector_serializer_if.sv | 32 +++
 rtl/feature_vector_serializer.sv | 149 ++++++++++++++
 tb/tb_feature_vector_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/feature_vector_serializer_if.sv
// Output stream bundle of feature_vector_serializer: one element per transfer,
// valid/ready handshake, with element index and last-element marker.
interface feature_vector_serializer_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FEATURES = 1280
);
    localparam int unsigned IDX_W = $clog2(FEATURES);

    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        out_index;
    logic                    out_last;

    // Serializer side drives the element stream.
    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    // Downstream consumer applies backpressure through out_ready.
    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/feature_vector_serializer.sv
// feature_vector_serializer: captures a parallel feature vector in one cycle and
// drains it as a valid/ready element stream, then pulses done for one cycle.
// Optional macro FVS_OVERRUN_DETECT_EN builds a sticky flag for vectors offered
// while a previous one is still draining; without it overrun is tied low.
module feature_vector_serializer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FEATURES = 1280
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] data_in [FEATURES],
    input  logic                    valid_in,
    output logic                    in_ready,
    feature_vector_serializer_if.master strm,
    output logic                    done,
    output logic                    overrun
);
    localparam int unsigned IDX_W = $clog2(FEATURES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    in_ready_q, in_ready_d;
    logic                    load_c;
    logic                    xfer_c;
    logic [IDX_W-1:0]        idx_inc_c;

    logic signed [WIDTH-1:0] vec_q [FEATURES];

    assign xfer_c    = en && valid_q && strm.out_ready;
    assign idx_inc_c = idx_q + IDX_W'(1);

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = done_q;
        in_ready_d = in_ready_q;
        load_c     = 1'b0;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        load_c     = 1'b1;
                        state_d    = STREAM;
                        idx_d      = '0;
                        data_d     = data_in[0];
                        valid_d    = 1'b1;
                        last_d     = 1'b0;
                        in_ready_d = 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer_c) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_inc_c;
                            data_d = vec_q[idx_inc_c];
                            last_d = (idx_inc_c == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    in_ready_d = 1'b1;
                end
                default: begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers; en low leaves every *_d equal to its *_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Vector buffer: written only when a vector is accepted in IDLE; no reset needed.
    always_ff @(posedge clk) begin
        if (load_c && !rst) begin
            vec_q <= data_in;
        end
    end

`ifdef FVS_OVERRUN_DETECT_EN
    logic ovr_q;

    // Sticky flag for a vector offered while the previous one is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (en && valid_in && (state_q != IDLE)) begin
            ovr_q <= 1'b1;
        end
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign in_ready       = in_ready_q;
    assign done           = done_q;
    assign strm.out_data  = data_q;
    assign strm.out_valid = valid_q;
    assign strm.out_index = idx_q;
    assign strm.out_last  = last_q;
endmodule

// File: tb/tb_feature_vector_serializer.sv
// Testbench for feature_vector_serializer with FEATURES=4: directed scenarios plus
// a randomized run, checked every cycle against a queue-based behavioural model.
module tb_feature_vector_serializer;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned FEATURES = 4;
`ifdef FVS_OVERRUN_DETECT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic valid_in;
    logic in_ready;
    logic done;
    logic overrun;
    logic signed [WIDTH-1:0] data_in [FEATURES];

    feature_vector_serializer_if #(.WIDTH(WIDTH), .FEATURES(FEATURES)) strm ();

    feature_vector_serializer #(.WIDTH(WIDTH), .FEATURES(FEATURES)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .valid_in (valid_in),
        .in_ready (in_ready),
        .strm     (strm),
        .done     (done),
        .overrun  (overrun)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference model: remaining elements of the vector in flight, position, pending done.
    logic [WIDTH-1:0] m_q [$];
    int m_pos;
    bit m_done;
    bit m_ovr;
    int cycle;
    int dut_acc [$];
    int n_vec;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    task automatic set_vec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        data_in[0] = a;
        data_in[1] = b;
        data_in[2] = c;
        data_in[3] = d;
    endtask

    // Advance the model on the current inputs, clock once, then compare every output.
    task automatic step();
        bit idle;
        bit idle_now;
        idle = (m_q.size() == 0) && !m_done;
        if (!rst && en && valid_in && in_ready) dut_acc.push_back(cycle);
        if (rst) begin
            m_q.delete();
            m_pos  = 0;
            m_done = 1'b0;
            m_ovr  = 1'b0;
        end else if (en) begin
            if (valid_in && !idle) m_ovr = m_ovr | OVR_EN;
            if (m_done) begin
                m_done = 1'b0;
            end else if (idle) begin
                if (valid_in) begin
                    for (int k = 0; k < int'(FEATURES); k++) m_q.push_back(data_in[k]);
                    m_pos = 0;
                end
            end else if (strm.out_ready) begin
                void'(m_q.pop_front());
                m_pos++;
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        idle_now = (m_q.size() == 0) && !m_done;
        chk("in_ready", 32'(in_ready), 32'(idle_now));
        chk("out_valid", 32'(strm.out_valid), 32'(m_q.size() != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_q.size() != 0) begin
            chk("out_data", 32'($unsigned(strm.out_data)), 32'(m_q[0]));
            chk("out_index", 32'(strm.out_index), 32'(m_pos));
            chk("out_last", 32'(strm.out_last), 32'(m_pos == int'(FEATURES) - 1));
        end else begin
            chk("out_last_idle", 32'(strm.out_last), 32'd0);
        end
        if (idle_now) chk("out_index_idle", 32'(strm.out_index), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cycle = 0;
        m_pos = 0;
        m_done = 1'b0;
        m_ovr = 1'b0;
        rst = 1'b1;
        en = 1'b1;
        valid_in = 1'b0;
        strm.out_ready = 1'b0;
        set_vec(16'h0, 16'h0, 16'h0, 16'h0);

        // Reset values.
        step();
        step();
        rst = 1'b0;
        step();

        // Basic stream with out_ready held high.
        set_vec(16'h0100, 16'hFF00, 16'h7FFF, 16'h8000);
        strm.out_ready = 1'b1;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Backpressure pattern 1,0,0,1,1,0,1.
        begin
            logic [6:0] pat;
            pat = 7'b1011001;
            strm.out_ready = 1'b0;
            valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            for (int i = 0; i < 7; i++) begin
                strm.out_ready = pat[i];
                step();
            end
            strm.out_ready = 1'b1;
            for (int i = 0; i < 3; i++) step();
        end

        // Input isolation and overrun.
        set_vec(16'h0A0A, 16'hB0B0, 16'h0C0C, 16'hD0D0);
        valid_in = 1'b1;
        strm.out_ready = 1'b0;
        step();
        set_vec(16'h1234, 16'h1234, 16'h1234, 16'h1234);
        step();
        strm.out_ready = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Enable freeze while element 1 is presented.
        set_vec(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Freeze the done pulse itself.
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        en = 1'b0;
        for (int i = 0; i < 2; i++) step();
        en = 1'b1;
        for (int i = 0; i < 2; i++) step();

        // Reset mid-stream after two transfers, then a fresh vector.
        set_vec(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_vec(16'd1, 16'd2, 16'd3, 16'd4);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Back-to-back vectors with valid_in held high.
        dut_acc.delete();
        set_vec(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        valid_in = 1'b1;
        for (int i = 0; i < 20 && dut_acc.size() < 2; i++) begin
            step();
            if (dut_acc.size() == 1) set_vec(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        end
        valid_in = 1'b0;
        chk("b2b_accepts", 32'(dut_acc.size()), 32'd2);
        if (dut_acc.size() == 2) chk("b2b_period", 32'(dut_acc[1] - dut_acc[0]), 32'(FEATURES + 2));
        for (int i = 0; i < 8; i++) step();

        // Randomized traffic: data, valid_in, out_ready, en and occasional reset.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(99) == 0);
            en = ($urandom_range(9) != 0);
            strm.out_ready = 1'($urandom_range(1));
            valid_in = ($urandom_range(2) == 0);
            if ($urandom_range(1) == 0) begin
                for (int k = 0; k < int'(FEATURES); k++) data_in[k] = WIDTH'($urandom);
            end
            step();
        end

        // Drain.
        rst = 1'b0;
        en = 1'b1;
        valid_in = 1'b0;
        strm.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
